// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and default sizes for the instruction prefetch buffer.
package ifetch_prefetch_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] NOP_WORD  = 16'h0000;
  localparam int          DEF_DEPTH = 4;
  localparam int          DEF_AW    = 8;
  localparam int          DEF_DW    = 16;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer holding prefetched instruction words; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wr_data,
  output logic [DW-1:0]          head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head_data = mem[rd_ptr];

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch buffer between the CPU fetch port and a handshaked instruction memory.
// Define IFETCH_PREFETCH_BYPASS_EN to forward an ack word straight to the CPU when the buffer is empty.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_take,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] head_addr, head_nxt;
  logic [AW-1:0] fetch_addr, fetch_nxt;
  logic [AW-1:0] addr_nxt;
  logic          req_nxt;
  logic          discard, discard_nxt;
  logic [CW-1:0] count;
  logic [DW-1:0] head_data;
  logic          hit, redirect, push, pop, bypass, bypass_take;

  assign hit      = (cpu_addr == head_addr) && (count != '0);
  assign redirect = (cpu_addr != head_addr);
  assign pop      = hit && cpu_take;

`ifdef IFETCH_PREFETCH_BYPASS_EN
  assign bypass    = (state == WAIT) && mem_ack && !discard && (count == '0)
                     && (mem_addr == cpu_addr) && (cpu_addr == head_addr);
  assign cpu_ready = hit || bypass;
  assign cpu_data  = hit ? head_data : (bypass ? mem_data : DW'(NOP_WORD));
`else
  assign bypass    = 1'b0;
  assign cpu_ready = hit;
  assign cpu_data  = hit ? head_data : DW'(NOP_WORD);
`endif

  assign bypass_take = bypass && cpu_take;
  // A word consumed through the bypass never enters the buffer.
  assign push = (state == WAIT) && mem_ack && !discard && !redirect && !bypass_take;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .wr_data   (mem_data),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    state_nxt   = state;
    req_nxt     = mem_req;
    addr_nxt    = mem_addr;
    discard_nxt = discard;
    head_nxt    = head_addr;
    fetch_nxt   = fetch_addr;

    if (pop || bypass_take) begin
      head_nxt = head_addr + AW'(1);
    end
    if (push || bypass_take) begin
      fetch_nxt = fetch_addr + AW'(1);
    end
    if (redirect) begin
      head_nxt  = cpu_addr;
      fetch_nxt = cpu_addr;
    end

    case (state)
      IDLE: begin
        // A redirect refetches from the new PC right away instead of the stale fetch_addr.
        if (redirect) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = cpu_addr;
        end else if (count < DEPTH_C) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_addr;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          req_nxt     = 1'b0;
          discard_nxt = 1'b0;
        end else if (redirect) begin
          discard_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      discard    <= 1'b0;
      head_addr  <= '0;
      fetch_addr <= '0;
    end else begin
      state      <= state_nxt;
      mem_req    <= req_nxt;
      mem_addr   <= addr_nxt;
      discard    <= discard_nxt;
      head_addr  <= head_nxt;
      fetch_addr <= fetch_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed self-checking bench for ifetch_prefetch with a latency-programmable memory model.
// Expectations adapt when IFETCH_PREFETCH_BYPASS_EN is defined.
module tb_ifetch_prefetch;

`ifdef IFETCH_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  cpu_addr;
  logic        cpu_take;
  logic [15:0] cpu_data;
  logic        cpu_ready;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;

  int lat;
  int wcnt;
  int vectors;
  int miscompares;

  ifetch_prefetch dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_take  (cpu_take),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory answers lat cycles after mem_req rises (lat = 0 acks in the first cycle).
  always @(posedge clock) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end
  assign mem_ack  = mem_req && (wcnt == lat);
  assign mem_data = mem_ack ? {8'h10, mem_addr} : 16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles, input logic [7:0] addr, input logic take);
    repeat (cycles) @(negedge clock);
    cpu_addr = addr;
    cpu_take = take;
    #1;
  endtask

  initial begin
    wcnt = 0;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cpu_addr = 8'h00;
    cpu_take = 1'b0;
    lat = 1;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_mem_req",   32'(mem_req),   0);
    checkOutput("rst_mem_addr",  32'(mem_addr),  0);
    checkOutput("rst_cpu_ready", 32'(cpu_ready), 0);
    checkOutput("rst_cpu_data",  32'(cpu_data),  0);
    checkOutput("rst_count",     32'(dut.count), 0);

    // Cold start from PC 0, memory acking one cycle after each request.
    reset = 1'b0;
    applyStimulus(1, 8'h00, 1'b0);
    checkOutput("c1_mem_req",   32'(mem_req),   1);
    checkOutput("c1_mem_addr",  32'(mem_addr),  0);
    checkOutput("c1_cpu_ready", 32'(cpu_ready), 0);
    applyStimulus(1, 8'h00, 1'b0);
    checkOutput("c2_ack_ready", 32'(cpu_ready), 32'(BYP));
    applyStimulus(1, 8'h00, 1'b0);
    checkOutput("c3_ready", 32'(cpu_ready), 1);
    checkOutput("c3_data",  32'(cpu_data),  32'h1000);

    // Hold take low until the buffer is full.
    applyStimulus(13, 8'h00, 1'b0);
    checkOutput("full_count",   32'(dut.count), 4);
    checkOutput("full_mem_req", 32'(mem_req),   0);
    checkOutput("full_data",    32'(cpu_data),  32'h1000);
    checkOutput("full_ready",   32'(cpu_ready), 1);

    // Sequential consumption.
    applyStimulus(1, 8'h00, 1'b1);
    checkOutput("seq0_data", 32'(cpu_data), 32'h1000);
    applyStimulus(1, 8'h01, 1'b1);
    checkOutput("seq1_data", 32'(cpu_data), 32'h1001);
    applyStimulus(1, 8'h02, 1'b1);
    checkOutput("seq2_data", 32'(cpu_data), 32'h1002);
    applyStimulus(1, 8'h03, 1'b1);
    checkOutput("seq3_data", 32'(cpu_data), 32'h1003);
    applyStimulus(1, 8'h04, 1'b0);
    checkOutput("seq4_ready", 32'(cpu_ready), 1);
    checkOutput("seq4_data",  32'(cpu_data),  32'h1004);

    // Asynchronous reset while a request is outstanding.
    applyStimulus(1, 8'h04, 1'b0);
    checkOutput("wait_mem_req",  32'(mem_req),  1);
    checkOutput("wait_mem_addr", 32'(mem_addr), 32'h05);
    reset = 1'b1;
    #1;
    checkOutput("arst_mem_req",   32'(mem_req),   0);
    checkOutput("arst_cpu_ready", 32'(cpu_ready), 0);
    checkOutput("arst_count",     32'(dut.count), 0);

    // Restart at PC 5, then jump to 0x40 while the fetch of 0x07 is pending.
    applyStimulus(1, 8'h05, 1'b0);
    reset = 1'b0;
    applyStimulus(1, 8'h05, 1'b0);
    checkOutput("r1_mem_addr",  32'(mem_addr),  32'h05);
    checkOutput("r1_cpu_ready", 32'(cpu_ready), 0);
    applyStimulus(2, 8'h05, 1'b0);
    checkOutput("r3_data", 32'(cpu_data), 32'h1005);
    applyStimulus(3, 8'h05, 1'b0);
    lat = 3;
    applyStimulus(1, 8'h05, 1'b0);
    checkOutput("r7_mem_req",  32'(mem_req),  1);
    checkOutput("r7_mem_addr", 32'(mem_addr), 32'h07);
    checkOutput("r7_data",     32'(cpu_data), 32'h1005);
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_ready", 32'(cpu_ready), 0);
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_hold_req",  32'(mem_req),  1);
    checkOutput("jmp_hold_addr", 32'(mem_addr), 32'h07);
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_stale_ack",   32'(mem_ack),   1);
    checkOutput("jmp_stale_ready", 32'(cpu_ready), 0);
    applyStimulus(1, 8'h40, 1'b0);
    lat = 1;
    checkOutput("jmp_idle_req", 32'(mem_req),   0);
    checkOutput("jmp_dropped",  32'(dut.count), 0);
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_new_req",  32'(mem_req),  1);
    checkOutput("jmp_new_addr", 32'(mem_addr), 32'h40);
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_ack_ready", 32'(cpu_ready), 32'(BYP));
    applyStimulus(1, 8'h40, 1'b0);
    checkOutput("jmp_ready2", 32'(cpu_ready), 1);
    checkOutput("jmp_data",   32'(cpu_data),  32'h1040);

    // Zero-wait memory: redirect to 0xFE and run across the address wrap.
    lat = 0;
    cpu_addr = 8'hFE;
    applyStimulus(1, 8'hFE, 1'b0);
    checkOutput("fe_mem_req",  32'(mem_req),   1);
    checkOutput("fe_mem_addr", 32'(mem_addr),  32'hFE);
    checkOutput("fe_c1_ready", 32'(cpu_ready), 32'(BYP));
    applyStimulus(1, 8'hFE, 1'b0);
    checkOutput("fe_c2_ready", 32'(cpu_ready), 1);
    checkOutput("fe_c2_data",  32'(cpu_data),  32'h10FE);
    applyStimulus(3, 8'hFE, 1'b0);
    checkOutput("wrap_mem_req",  32'(mem_req),  1);
    checkOutput("wrap_mem_addr", 32'(mem_addr), 32'h00);
    applyStimulus(1, 8'hFE, 1'b1);
    checkOutput("wrap_fe", 32'(cpu_data), 32'h10FE);
    applyStimulus(1, 8'hFF, 1'b1);
    checkOutput("wrap_ff_ready", 32'(cpu_ready), 1);
    checkOutput("wrap_ff",       32'(cpu_data),  32'h10FF);
    applyStimulus(1, 8'h00, 1'b1);
    checkOutput("wrap_00_ready", 32'(cpu_ready), 1);
    checkOutput("wrap_00",       32'(cpu_data),  32'h1000);
    applyStimulus(1, 8'h01, 1'b0);
    checkOutput("wrap_01", 32'(cpu_data), 32'h1001);

    // Redirect to 0x20 with take high: bypass consumes the ack word directly.
    applyStimulus(1, 8'h20, 1'b1);
    checkOutput("b20_c0_ready", 32'(cpu_ready), 0);
    applyStimulus(1, 8'h20, 1'b1);
    checkOutput("b20_mem_req",  32'(mem_req),   1);
    checkOutput("b20_mem_addr", 32'(mem_addr),  32'h20);
    checkOutput("b20_c1_ready", 32'(cpu_ready), 32'(BYP));
    checkOutput("b20_c1_data",  32'(cpu_data),  BYP ? 32'h1020 : 32'h0);
    if (BYP) begin
      applyStimulus(1, 8'h21, 1'b0);
      checkOutput("b20_c2_ready", 32'(cpu_ready), 0);
    end else begin
      applyStimulus(1, 8'h20, 1'b1);
      checkOutput("b20_c2_ready", 32'(cpu_ready), 1);
      checkOutput("b20_c2_data",  32'(cpu_data),  32'h1020);
    end
    applyStimulus(1, 8'h21, 1'b0);
    checkOutput("b21_mem_req",  32'(mem_req),   1);
    checkOutput("b21_mem_addr", 32'(mem_addr),  32'h21);
    checkOutput("b21_ready",    32'(cpu_ready), 32'(BYP));
    checkOutput("b21_data",     32'(cpu_data),  BYP ? 32'h1021 : 32'h0);
    applyStimulus(1, 8'h21, 1'b0);
    checkOutput("b21_ready2", 32'(cpu_ready), 1);
    checkOutput("b21_data2",  32'(cpu_data),  32'h1021);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction prefetch buffer between the PCPU instruction port (i_addr/i_datain) and a slower handshaked instruction memory.
- Keeps a small FIFO of sequential instruction words starting at the CPU's expected PC.
- Drives the CPU enable (cpu_ready) low on a miss or redirect, and flushes and refetches on any non-sequential PC (jump/branch).

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 8, instruction address width.
- DW, 16, instruction word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  AW  PCPU i_addr (current PC).
- cpu_take  in  1  CPU consumes the presented word this cycle (PC advances).
- cpu_data  out  DW  instruction word to PCPU i_datain.
- cpu_ready  out  1  cpu_data is valid for cpu_addr; drives PCPU enable.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  AW  fetch address; stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_data is valid and the request is done.
- mem_data  in  DW  fetched word.

Behaviour:
Reset (asynchronous, active-high):
- mem_req = 0, mem_addr = 0, cpu_ready = 0, cpu_data = 16'h0000 (NOP).
- FIFO count = 0, head_addr = 0, fetch_addr = 0, state = IDLE, discard = 0.
- Reset asserted mid-request drops the request. The memory must tolerate mem_req falling without an ack.

Hit, pop and redirect:
- head_addr is the address of the FIFO head. It is kept even when the FIFO is empty.
- hit = (cpu_addr == head_addr) && count != 0. cpu_ready = hit, and cpu_data = head word, both combinational. When there is no hit, cpu_data = 16'h0000.
- Pop on a clock edge when hit && cpu_take: head_addr increments, wrapping 8'hFF -> 8'h00.
- Redirect when cpu_addr != head_addr. At the next edge:
  - count = 0, head_addr = fetch_addr = cpu_addr.
  - If a request is outstanding with no ack this cycle, set discard = 1.
- A redirect takes priority over a pop and a push in the same cycle. Ack data arriving in the redirect cycle is dropped.

FSM states:
- IDLE: issue a request when count + outstanding < DEPTH. Next edge: mem_req = 1, mem_addr = fetch_addr, go to WAIT.
- WAIT: hold mem_req and mem_addr. On mem_ack, at that edge:
  - if discard = 0, push mem_data and increment fetch_addr (wraps);
  - clear discard and mem_req, go to IDLE.
  - mem_ack may arrive in the first cycle of mem_req.
- At most one request is outstanding. No new request is issued in the ack cycle.

Limits and latency:
- Full (count == DEPTH): no request. A pop and a push in the same cycle are both allowed and leave count unchanged.
- Miss penalty with a zero-wait memory: redirect at cycle C, mem_req at C+1, ack at C+1, cpu_ready at C+2.
- Steady state: one push every 2 cycles.

Optional Feature:
- IFETCH_PREFETCH_BYPASS_EN defined:
  - When count == 0, mem_ack = 1, discard = 0 and mem_addr == cpu_addr == head_addr, drive cpu_ready = 1 and cpu_data = mem_data combinationally.
  - If cpu_take is also high, the word is not pushed and head_addr/fetch_addr both increment. This makes the miss penalty C+1.
- Undefined: no combinational path from mem_* to cpu_*.

Decomposition:
- Package ifetch_prefetch_pkg holds:
  - state enum {IDLE, WAIT};
  - NOP_WORD = 16'h0000;
  - the default DEPTH/AW/DW constants.
- Sub-module ifetch_fifo: circular buffer with DEPTH entries, rd/wr pointers, count, and a synchronous clear input. It exposes head data, push, pop and flush.
- Address compare, FSM and bypass stay in the top level.

Test Plan:
- Reset, then cpu_addr = 8'h00 with a memory returning data = addr + 16'h1000 and ack 1 cycle after req -> cpu_ready is low until the first push, then cpu_data = 16'h1000; sequential take yields 16'h1001, 16'h1002, ...
- cpu_take held low with the FIFO full -> count stays 4, mem_req stays 0, and cpu_data is stable at the head word.
- Jump from cpu_addr 8'h05 to 8'h40 while a request for 8'h07 is outstanding (ack after 3 cycles) -> ack data is discarded, the next mem_addr = 8'h40, and the first valid cpu_data = 16'h1040.
- Sequential run across 8'hFE, 8'hFF, 8'h00 -> mem_addr wraps to 8'h00, there is no redirect, and cpu_data = 16'h10FF then 16'h1000.
- Reset asserted while in WAIT -> mem_req = 0 and cpu_ready = 0 immediately (asynchronous), with count = 0 afterwards.
- Bypass: with IFETCH_PREFETCH_BYPASS_EN, a zero-wait memory and a redirect to 8'h20 -> cpu_ready at C+1 with cpu_data = 16'h1020. Without the macro, cpu_ready is at C+2.
